// File: rtl/simon_datapath_param.sv
// Simon game datapath: stores a growing pattern sequence, plays it back with a
// fixed per-step hold time, checks the player's repeat and loops it when done.
module simon_datapath_param #(
  parameter int WIDTH   = 4,
  parameter int DEPTH   = 64,
  parameter int PB_HOLD = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       level,
  input  logic [WIDTH-1:0]           pattern,
  input  logic                       btn_valid,
  input  logic                       restart,
  output logic [WIDTH-1:0]           leds,
  output logic [2:0]                 mode_leds,
  output logic                       win,
  output logic [$clog2(DEPTH):0]     score
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int HW = (PB_HOLD > 1) ? $clog2(PB_HOLD) : 1;

  typedef enum logic [1:0] {
    S_INPUT    = 2'd0,
    S_PLAYBACK = 2'd1,
    S_REPEAT   = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    len_q, len_d;
  logic [AW-1:0]    pb_idx_q, pb_idx_d;
  logic [AW-1:0]    rp_idx_q, rp_idx_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             win_q, win_d;
  logic             level_q, level_d;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             mem_we;
  logic [WIDTH-1:0] rd_pb;
  logic [WIDTH-1:0] rd_rp;

  logic             legal;
  logic             hold_last;
  logic             pb_last;
  logic             rp_last;
  logic             len_full;
  logic [LW-1:0]    len_m1;

  assign rd_pb     = mem_q[pb_idx_q];
  assign rd_rp     = mem_q[rp_idx_q];
  assign legal     = level_q ? (pattern != '0) : $onehot(pattern);
  assign hold_last = (hold_q == HW'(PB_HOLD - 1));
  assign len_m1    = len_q - LW'(1);
  assign pb_last   = ({1'b0, pb_idx_q} == len_m1);
  assign rp_last   = ({1'b0, rp_idx_q} == len_m1);
  assign len_full  = (len_q == LW'(DEPTH));

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    pb_idx_d = pb_idx_q;
    rp_idx_d = rp_idx_q;
    hold_d   = hold_q;
    win_d    = win_q;
    mem_we   = 1'b0;
    // Difficulty is sampled only while the game has not started yet.
    level_d  = (state_q == S_INPUT && len_q == '0) ? level : level_q;

    if (restart) begin
      state_d  = S_INPUT;
      len_d    = '0;
      pb_idx_d = '0;
      rp_idx_d = '0;
      hold_d   = '0;
      win_d    = 1'b0;
    end else begin
      case (state_q)
        S_INPUT: begin
          if (btn_valid && legal) begin
            mem_we   = 1'b1;
            len_d    = len_q + LW'(1);
            pb_idx_d = '0;
            hold_d   = '0;
            state_d  = S_PLAYBACK;
          end
        end

        S_PLAYBACK: begin
          if (hold_last) begin
            hold_d = '0;
            if (pb_last) begin
              rp_idx_d = '0;
              state_d  = S_REPEAT;
            end else begin
              pb_idx_d = pb_idx_q + AW'(1);
            end
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end

        S_REPEAT: begin
          if (btn_valid) begin
            if (pattern == rd_rp) begin
              if (!rp_last) begin
                rp_idx_d = rp_idx_q + AW'(1);
              end else if (len_full) begin
                win_d    = 1'b1;
                pb_idx_d = '0;
                hold_d   = '0;
                state_d  = S_DONE;
              end else begin
                state_d = S_INPUT;
              end
            end else begin
              win_d    = 1'b0;
              pb_idx_d = '0;
              hold_d   = '0;
              state_d  = S_DONE;
            end
          end
        end

        S_DONE: begin
          if (hold_last) begin
            hold_d   = '0;
            pb_idx_d = pb_last ? '0 : pb_idx_q + AW'(1);
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end

        default: state_d = S_INPUT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_INPUT;
      len_q    <= '0;
      pb_idx_q <= '0;
      rp_idx_q <= '0;
      hold_q   <= '0;
      win_q    <= 1'b0;
      level_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      pb_idx_q <= pb_idx_d;
      rp_idx_q <= rp_idx_d;
      hold_q   <= hold_d;
      win_q    <= win_d;
      level_q  <= level_d;
    end
  end

  // Memory is not reset; rst gating keeps a reset edge from landing a write.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem_q[len_q[AW-1:0]] <= pattern;
    end
  end

  always_comb begin
    leds      = pattern;
    mode_leds = 3'b001;
    case (state_q)
      S_INPUT: begin
        leds      = pattern;
        mode_leds = 3'b001;
      end
      S_PLAYBACK: begin
        leds      = rd_pb;
        mode_leds = 3'b010;
      end
      S_REPEAT: begin
        leds      = pattern;
        mode_leds = 3'b100;
      end
      S_DONE: begin
        leds      = rd_pb;
        mode_leds = 3'b111;
      end
      default: begin
        leds      = pattern;
        mode_leds = 3'b001;
      end
    endcase
  end

  assign win   = win_q;
  assign score = len_q;

endmodule

// File: tb/tb_simon_datapath_param.sv
// Bench for simon_datapath_param: directed table, hand-written corner cases and
// random play against a sequence-level reference model; small-depth instance too.
module tb_simon_datapath_param;

  localparam int H = 4;
  localparam int D = 64;
  localparam int M_IN = 0, M_PB = 1, M_RP = 2, M_DN = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       level = 1'b0, btn_valid = 1'b0, restart = 1'b0;
  logic [3:0] pattern = '0;
  logic [3:0] leds;
  logic [2:0] mode_leds;
  logic       win;
  logic [6:0] score;

  logic       s_level = 1'b0, s_btn = 1'b0, s_restart = 1'b0;
  logic [3:0] s_pattern = '0;
  logic [3:0] s_leds;
  logic [2:0] s_mode;
  logic       s_win;
  logic [2:0] s_score;

  always #5 clk = ~clk;

  simon_datapath_param #(.WIDTH(4), .DEPTH(D), .PB_HOLD(H)) u_dut (
    .clk(clk), .rst(rst), .level(level), .pattern(pattern), .btn_valid(btn_valid),
    .restart(restart), .leds(leds), .mode_leds(mode_leds), .win(win), .score(score));

  simon_datapath_param #(.WIDTH(4), .DEPTH(4), .PB_HOLD(1)) u_small (
    .clk(clk), .rst(rst), .level(s_level), .pattern(s_pattern), .btn_valid(s_btn),
    .restart(s_restart), .leds(s_leds), .mode_leds(s_mode), .win(s_win), .score(s_score));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the game as a stored list plus time spent in the phase.
  int         m_mode = M_IN;
  logic [3:0] m_seq[$];
  int         m_t = 0, m_rp = 0;
  bit         m_win = 0, m_lvl = 0;

  task automatic model_reset();
    m_mode = M_IN; m_seq.delete(); m_t = 0; m_rp = 0; m_win = 0; m_lvl = 0;
  endtask

  task automatic model_exp(input logic [3:0] p, output logic [3:0] el,
                           output logic [2:0] em, output int es);
    es = m_seq.size();
    case (m_mode)
      M_PB:    begin el = m_seq[m_t / H]; em = 3'b010; end
      M_RP:    begin el = p; em = 3'b100; end
      M_DN:    begin el = m_seq[(m_t / H) % m_seq.size()]; em = 3'b111; end
      default: begin el = p; em = 3'b001; end
    endcase
  endtask

  task automatic model_step(input bit rs, input bit bt, input bit lv, input logic [3:0] p);
    bit pre_lvl = (m_mode == M_IN && m_seq.size() == 0);
    bit legal = m_lvl ? (p != 0) : ($countones(p) == 1);
    if (rs) begin
      m_mode = M_IN; m_seq.delete(); m_t = 0; m_rp = 0; m_win = 0;
    end else begin
      case (m_mode)
        M_IN: if (bt && legal) begin m_seq.push_back(p); m_mode = M_PB; m_t = 0; end
        M_PB: begin
          m_t++;
          if (m_t == m_seq.size() * H) begin m_mode = M_RP; m_rp = 0; end
        end
        M_RP: if (bt) begin
          if (p == m_seq[m_rp]) begin
            if (m_rp < m_seq.size() - 1) m_rp++;
            else if (m_seq.size() == D) begin m_mode = M_DN; m_win = 1; m_t = 0; end
            else m_mode = M_IN;
          end else begin
            m_mode = M_DN; m_win = 0; m_t = 0;
          end
        end
        default: m_t++;
      endcase
    end
    if (pre_lvl) m_lvl = lv;
  endtask

  typedef struct {
    bit rs; bit bt; bit lv; logic [3:0] p;
    int e_score; logic [2:0] e_mode; logic [3:0] e_leds; bit e_win;
  } vec_t;

  function automatic vec_t mk(bit rs, bit bt, bit lv, logic [3:0] p, int sc = 0,
                              logic [2:0] md = 3'b0, logic [3:0] ld = 4'b0, bit w = 0);
    vec_t v;
    v.rs = rs; v.bt = bt; v.lv = lv; v.p = p;
    v.e_score = sc; v.e_mode = md; v.e_leds = ld; v.e_win = w;
    return v;
  endfunction

  // One clock of the big DUT: outputs compared at the falling edge.
  task automatic cyc(input vec_t v, input bit use_tbl);
    logic [3:0] el; logic [2:0] em; int es;
    restart = v.rs; btn_valid = v.bt; level = v.lv; pattern = v.p;
    @(negedge clk);
    model_exp(v.p, el, em, es);
    chk("model_leds", leds, el);
    chk("model_mode", mode_leds, em);
    chk("model_score", score, es);
    chk("model_win", win, m_win);
    if (use_tbl) begin
      chk("tbl_leds", leds, v.e_leds);
      chk("tbl_mode", mode_leds, v.e_mode);
      chk("tbl_score", score, v.e_score);
      chk("tbl_win", win, v.e_win);
    end
    model_step(v.rs, v.bt, v.lv, v.p);
    @(posedge clk); #1;
  endtask

  task automatic idle_until(input int mode, input int budget);
    int n = 0;
    while (m_mode != mode && n < budget) begin
      cyc(mk(0, 0, 0, 4'b0), 0);
      n++;
    end
    checks++;
    if (m_mode != mode) begin
      errors++;
      $display("FAIL idle_until: model mode %0d, wanted %0d", m_mode, mode);
    end
  endtask

  vec_t tbl[$];

  initial begin
    logic [3:0] sp [4];
    bit cur_lv;
    int n;

    tbl.push_back(mk(0, 1, 0, 4'b0011, 0, 3'b001, 4'b0011));
    tbl.push_back(mk(0, 1, 0, 4'b0100, 0, 3'b001, 4'b0100));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 4'b0000, 1, 3'b010, 4'b0100));
    tbl.push_back(mk(0, 1, 0, 4'b0100, 1, 3'b100, 4'b0100));
    tbl.push_back(mk(0, 1, 0, 4'b0001, 1, 3'b001, 4'b0001));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 4'b0000, 2, 3'b010, 4'b0100));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 4'b0000, 2, 3'b010, 4'b0001));
    tbl.push_back(mk(0, 1, 0, 4'b0100, 2, 3'b100, 4'b0100));
    tbl.push_back(mk(0, 1, 0, 4'b0010, 2, 3'b100, 4'b0010));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 4'b0000, 2, 3'b111, 4'b0100));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 4'b0000, 2, 3'b111, 4'b0001));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 2, 3'b111, 4'b0100));
    tbl.push_back(mk(1, 0, 0, 4'b0000, 2, 3'b111, 4'b0100));
    tbl.push_back(mk(0, 0, 1, 4'b1011, 0, 3'b001, 4'b1011));
    tbl.push_back(mk(0, 1, 1, 4'b1011, 0, 3'b001, 4'b1011));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 4'b0000, 1, 3'b010, 4'b1011));
    tbl.push_back(mk(0, 1, 0, 4'b1011, 1, 3'b100, 4'b1011));
    tbl.push_back(mk(0, 1, 0, 4'b1011, 1, 3'b001, 4'b1011));
    tbl.push_back(mk(0, 0, 0, 4'b0000, 2, 3'b010, 4'b1011));

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    pattern = 4'b1001;
    #1;
    chk("reset_leds", leds, 4'b1001);
    chk("reset_mode", mode_leds, 3'b001);
    chk("reset_score", score, 0);
    chk("reset_win", win, 0);
    @(posedge clk); #1;

    foreach (tbl[i]) cyc(tbl[i], 1);

    // Grow to length 3, then hit rst in the middle of playback.
    idle_until(M_RP, 20);
    cyc(mk(0, 1, 0, 4'b1011), 0);
    cyc(mk(0, 1, 0, 4'b1011), 0);
    cyc(mk(0, 1, 0, 4'b0110), 0);
    cyc(mk(0, 0, 0, 4'b0000), 0);
    chk("pre_rst_score", score, 3);
    chk("pre_rst_mode", mode_leds, 3'b010);
    pattern = 4'b0010;
    rst = 1'b1;
    #1;
    chk("async_rst_mode", mode_leds, 3'b001);
    chk("async_rst_score", score, 0);
    chk("async_rst_leds", leds, 4'b0010);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;

    // restart and btn_valid together: nothing is stored.
    cyc(mk(0, 0, 0, 4'b0000), 0);
    cyc(mk(1, 1, 0, 4'b0100), 0);
    cyc(mk(0, 0, 0, 4'b0000), 0);
    chk("restart_btn_score", score, 0);
    chk("restart_btn_mode", mode_leds, 3'b001);

    // Random play against the model.
    cur_lv = 0;
    for (int i = 0; i < 6000 && errors < 40; i++) begin
      bit rs, bt; logic [3:0] p;
      rs = ($urandom_range(299) == 0);
      p  = 4'($urandom);
      bt = ($urandom_range(1) == 0);
      if (m_mode == M_IN) begin
        bt = ($urandom_range(2) == 0);
        if ($urandom_range(7) == 0) cur_lv = ~cur_lv;
      end else if (m_mode == M_RP && $urandom_range(19) != 0) begin
        p = m_seq[m_rp];
      end
      cyc(mk(rs, bt, cur_lv, p), 0);
    end

    // Perfect game to full depth, then watch DONE wrap around.
    cyc(mk(1, 0, 0, 4'b0000), 0);
    cyc(mk(0, 0, 0, 4'b0000), 0);
    n = 0;
    while (m_mode != M_DN && n < 30000 && errors < 40) begin
      if (m_mode == M_IN)      cyc(mk(0, 1, 0, 4'(1 << $urandom_range(3))), 0);
      else if (m_mode == M_RP) cyc(mk(0, 1, 0, m_seq[m_rp]), 0);
      else                     cyc(mk(0, 0, 0, 4'($urandom)), 0);
      n++;
    end
    chk("full_win", win, 1);
    chk("full_score", score, 64);
    for (int i = 0; i < 300; i++) cyc(mk(0, i % 3 == 0, 0, 4'($urandom)), 0);

    // Small instance: DEPTH=4, PB_HOLD=1.
    sp[0] = 4'b0010; sp[1] = 4'b1000; sp[2] = 4'b0001; sp[3] = 4'b0100;
    s_restart = 1'b1;
    @(posedge clk); #1 s_restart = 1'b0;
    for (int r = 0; r < 4; r++) begin
      s_btn = 1'b1; s_pattern = sp[r];
      @(posedge clk); #1 s_btn = 1'b0; s_pattern = '0;
      n = 0;
      while (s_mode == 3'b010 && n < 20) begin
        @(posedge clk); #1 n++;
      end
      chk("small_pb_len", n, r + 1);
      chk("small_repeat_mode", s_mode, 3'b100);
      for (int k = 0; k <= r; k++) begin
        s_btn = 1'b1; s_pattern = sp[k];
        @(posedge clk); #1;
      end
      s_btn = 1'b0; s_pattern = '0;
      chk("small_round_mode", s_mode, (r < 3) ? 3'b001 : 3'b111);
    end
    chk("small_win", s_win, 1);
    chk("small_score", s_score, 4);
    for (int k = 0; k < 8; k++) begin
      chk("small_done_leds", s_leds, sp[k % 4]);
      @(posedge clk); #1;
    end
    s_restart = 1'b1;
    @(posedge clk); #1 s_restart = 1'b0;
    chk("small_restart_mode", s_mode, 3'b001);
    chk("small_restart_score", s_score, 0);
    chk("small_restart_win", s_win, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/simon_datapath_param.md
Name: simon_datapath_param

Overview:
- Parametrised next-generation Simon game datapath with an integrated sequencer.
- Stores the growing pattern sequence in an internal DEPTH x WIDTH memory and plays it back with a programmable per-step hold time.
- Checks the player's repeat and cycles the stored sequence in the done state.
- Generalises the 4-button / 64-entry design to any button count and depth; adds timed playback, an explicit win/lose flag and a score output.

Parameters:
- WIDTH, 4, number of buttons/LEDs (pattern bits), >=2
- DEPTH, 64, max sequence length (memory entries), power of 2, >=2
- PB_HOLD, 4, clock cycles each entry is shown in PLAYBACK/DONE, >=1

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-high reset
- level  input  1  difficulty: 0 = one-hot patterns only, 1 = any nonzero pattern
- pattern  input  WIDTH  player switch/button value
- btn_valid  input  1  one-cycle strobe: pattern is submitted this cycle
- restart  input  1  one-cycle strobe: start a new game
- leds  output  WIDTH  pattern LEDs
- mode_leds  output  3  001 INPUT, 010 PLAYBACK, 100 REPEAT, 111 DONE
- win  output  1  1 = memory filled and fully repeated; valid in DONE
- score  output  clog2(DEPTH)+1  current sequence length (len)

Behaviour:
- Reset (rst=1, async): state=INPUT, len=0, pb_idx=0, rp_idx=0, hold_cnt=0, win=0, level_q=0. Memory contents are not cleared and are don't-care. Outputs after reset: leds=pattern, mode_leds=001, score=0.
- level_q loads level every cycle while state==INPUT and len==0; it is frozen otherwise.
- Legality:
  - level_q=0: pattern has exactly one bit set.
  - level_q=1: pattern != 0.
- Memory: synchronous write, asynchronous read.
- INPUT:
  - leds=pattern (live echo).
  - btn_valid with a legal pattern: mem[len]<=pattern, len<=len+1, pb_idx<=0, hold_cnt<=0, next state PLAYBACK.
  - Illegal pattern or no strobe: stay; nothing written.
- PLAYBACK:
  - leds=mem[pb_idx]. hold_cnt counts 0..PB_HOLD-1.
  - At PB_HOLD-1: if pb_idx==len-1, go to REPEAT with rp_idx=0; else pb_idx++ and hold_cnt=0.
  - btn_valid is ignored.
  - Total duration is exactly len*PB_HOLD cycles.
- REPEAT:
  - leds=pattern.
  - btn_valid with pattern==mem[rp_idx] (the legality rule does not apply here):
    - rp_idx<len-1: rp_idx++.
    - rp_idx==len-1 and len<DEPTH: go to INPUT.
    - rp_idx==len-1 and len==DEPTH: go to DONE with win=1.
  - btn_valid with a mismatch: go to DONE with win=0.
  - On entry to DONE: pb_idx=0, hold_cnt=0.
- DONE:
  - leds=mem[pb_idx], advancing every PB_HOLD cycles.
  - Wraps from len-1 to 0 indefinitely. len>=1 is guaranteed here.
  - btn_valid is ignored.
- restart (any state): next cycle state=INPUT, len=0, indices 0, hold_cnt=0, win=0.
- restart and btn_valid in the same cycle: restart wins and nothing is written.
- Width rules:
  - len has width clog2(DEPTH)+1 and holds 0..DEPTH.
  - Indices have width clog2(DEPTH).
  - The write at len==DEPTH is unreachable, because INPUT is never re-entered at full length.
- rst asserted mid-PLAYBACK/REPEAT: immediate return to the reset values, with no partial write.
- All state, counters and win are registered. leds and mode_leds are combinational from state, indices, memory and pattern.

Test Plan:
- Reset then level=0, pattern=4'b0011, btn_valid -> no write; score=0, mode_leds=001. Then pattern=4'b0100, btn_valid -> score=1, mode_leds=010, leds=0100 for exactly 4 cycles, then mode_leds=100.
- REPEAT with 0100 submitted -> INPUT. Add 0001 -> playback shows 0100 x4 cycles then 0001 x4 cycles (8 cycles total), then REPEAT.
- Stored sequence 0100,0001; submit 0100 then 0010 -> DONE, win=0, mode_leds=111. leds cycles 0100,0001,0100,... every 4 cycles.
- level=1 at start: pattern 4'b1011 accepted; after it is stored, changing level to 0 does not make 1011 illegal on the next input.
- DEPTH=4, PB_HOLD=1: four correct rounds -> DONE with win=1, score=4. A following restart -> INPUT, score=0, win=0.
- rst pulse mid-PLAYBACK (score=3) -> immediately mode_leds=001, score=0. Same-cycle restart+btn_valid in INPUT -> score stays 0.
